// File: rtl/sb_pkg.sv
// Shared constants and types for the decode-stage register scoreboard.
package sb_pkg;

    parameter int unsigned NUM_GPR = 32;
    parameter int unsigned CNT_W   = 2;
    parameter int unsigned REG_W   = 5;
    parameter int unsigned SB_MAX  = (1 << CNT_W) - 1;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dest;
    } sb_upd_t;

endpackage

// File: rtl/sb_counter.sv
// Saturating up/down counter; simultaneous inc and dec cancel, clr wins over both.
module sb_counter #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         clr,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         nz,
    output logic         err
);

    localparam logic [W-1:0] CntMax = '1;

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        err   = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !dec) begin
            if (cnt_q == CntMax) err = 1'b1;
            else                 cnt_d = cnt_q + 1'b1;
        end else if (dec && !inc) begin
            if (cnt_q == '0) err = 1'b1;
            else             cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
    assign nz  = (cnt_q != '0);

endmodule

// File: rtl/id_scoreboard.sv
// Per-GPR in-flight write/load tracking and the decode-stage stall it implies.
module id_scoreboard #(
    parameter int unsigned NUM_GPR = sb_pkg::NUM_GPR,
    parameter int unsigned CNT_W   = sb_pkg::CNT_W
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       issue_fire,
    input  logic       issue_we,
    input  logic [4:0] issue_dest,
    input  logic       issue_is_load,
    input  logic       ld_done_valid,
    input  logic [4:0] ld_done_dest,
    input  logic       wb_valid,
    input  logic [4:0] wb_dest,
    input  logic       flush,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic       rs_use,
    input  logic       rt_use,
    input  logic [4:0] dest_q,
    input  logic       dest_we_q,
    output logic       rs_pending,
    output logic       rt_pending,
    output logic       rs_ld_pending,
    output logic       rt_ld_pending,
    output logic       ds_stall,
    output logic       sb_err
);

    import sb_pkg::*;

    localparam logic [CNT_W-1:0] CntMax = '1;

    sb_upd_t wr_inc, ld_inc, wr_dec, ld_dec;

    assign wr_inc = '{valid: issue_fire & issue_we,                 dest: issue_dest};
    assign ld_inc = '{valid: issue_fire & issue_we & issue_is_load, dest: issue_dest};
    assign wr_dec = '{valid: wb_valid,                              dest: wb_dest};
    assign ld_dec = '{valid: ld_done_valid,                         dest: ld_done_dest};

    logic [CNT_W-1:0]   wr_cnt [NUM_GPR];
    logic [CNT_W-1:0]   ld_cnt [NUM_GPR];
    logic [NUM_GPR-1:0] wr_nz, ld_nz, wr_err, ld_err, order_err;

    // r0 is architecturally zero, so it never owes a write-back.
    assign wr_cnt[0]    = '0;
    assign ld_cnt[0]    = '0;
    assign wr_nz[0]     = 1'b0;
    assign ld_nz[0]     = 1'b0;
    assign wr_err[0]    = 1'b0;
    assign ld_err[0]    = 1'b0;
    assign order_err[0] = 1'b0;

    for (genvar r = 1; r < NUM_GPR; r++) begin : g_reg
        localparam logic [4:0] RegIdx = 5'(r);

        sb_counter #(.W(CNT_W)) u_wr_cnt (
            .clk    (clk),
            .resetn (resetn),
            .clr    (flush),
            .inc    (wr_inc.valid && wr_inc.dest == RegIdx),
            .dec    (wr_dec.valid && wr_dec.dest == RegIdx),
            .cnt    (wr_cnt[r]),
            .nz     (wr_nz[r]),
            .err    (wr_err[r])
        );

        sb_counter #(.W(CNT_W)) u_ld_cnt (
            .clk    (clk),
            .resetn (resetn),
            .clr    (flush),
            .inc    (ld_inc.valid && ld_inc.dest == RegIdx),
            .dec    (ld_dec.valid && ld_dec.dest == RegIdx),
            .cnt    (ld_cnt[r]),
            .nz     (ld_nz[r]),
            .err    (ld_err[r])
        );

        // Every pending load is also a pending write, so ld must never exceed wr.
        assign order_err[r] = (ld_cnt[r] > wr_cnt[r]);
    end

    logic sb_err_q, sb_err_d;

    always_comb begin
        sb_err_d = sb_err_q | (|wr_err) | (|ld_err) | (|order_err);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) sb_err_q <= 1'b0;
        else         sb_err_q <= sb_err_d;
    end

    assign sb_err = sb_err_q;

    always_comb begin
        rs_pending    = wr_nz[rs];
        rt_pending    = wr_nz[rt];
        rs_ld_pending = ld_nz[rs];
        rt_ld_pending = ld_nz[rt];
        // ALU results forward, so only loads or a full counter hold decode.
        ds_stall = (rs_use & rs_ld_pending) | (rt_use & rt_ld_pending)
                 | (dest_we_q & (dest_q != 5'd0) & (wr_cnt[dest_q] == CntMax));
    end

endmodule

// File: tb/tb_id_scoreboard.sv
// Directed self-checking bench for id_scoreboard.
module tb_id_scoreboard;

    logic       clk;
    logic       resetn;
    logic       issue_fire, issue_we, issue_is_load;
    logic [4:0] issue_dest;
    logic       ld_done_valid;
    logic [4:0] ld_done_dest;
    logic       wb_valid;
    logic [4:0] wb_dest;
    logic       flush;
    logic [4:0] rs, rt, dest_q;
    logic       rs_use, rt_use, dest_we_q;
    logic       rs_pending, rt_pending, rs_ld_pending, rt_ld_pending, ds_stall, sb_err;

    int n_checks = 0;
    int n_errors = 0;

    id_scoreboard dut (
        .clk           (clk),
        .resetn        (resetn),
        .issue_fire    (issue_fire),
        .issue_we      (issue_we),
        .issue_dest    (issue_dest),
        .issue_is_load (issue_is_load),
        .ld_done_valid (ld_done_valid),
        .ld_done_dest  (ld_done_dest),
        .wb_valid      (wb_valid),
        .wb_dest       (wb_dest),
        .flush         (flush),
        .rs            (rs),
        .rt            (rt),
        .rs_use        (rs_use),
        .rt_use        (rt_use),
        .dest_q        (dest_q),
        .dest_we_q     (dest_we_q),
        .rs_pending    (rs_pending),
        .rt_pending    (rt_pending),
        .rs_ld_pending (rs_ld_pending),
        .rt_ld_pending (rt_ld_pending),
        .ds_stall      (ds_stall),
        .sb_err        (sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_events();
        issue_fire    = 1'b0;
        issue_we      = 1'b0;
        issue_is_load = 1'b0;
        issue_dest    = 5'd0;
        ld_done_valid = 1'b0;
        ld_done_dest  = 5'd0;
        wb_valid      = 1'b0;
        wb_dest       = 5'd0;
        flush         = 1'b0;
    endtask

    task automatic clear_decode();
        rs = 5'd0; rt = 5'd0; rs_use = 1'b0; rt_use = 1'b0;
        dest_q = 5'd0; dest_we_q = 1'b0;
    endtask

    // One clock edge, then sample/drive 1 ns later; one-shot events drop afterwards.
    task automatic tick();
        @(posedge clk);
        #1;
        clear_events();
    endtask

    task automatic issue(input logic [4:0] d, input logic is_load);
        issue_fire = 1'b1; issue_we = 1'b1; issue_dest = d; issue_is_load = is_load;
    endtask

    initial begin
        clear_events();
        clear_decode();
        resetn = 1'b0;
        rs = 5'd5; rs_use = 1'b1;
        #12;
        check("reset_rs_pending", rs_pending, 0);
        check("reset_ds_stall",   ds_stall,   0);
        check("reset_sb_err",     sb_err,     0);
        resetn = 1'b1;
        tick();
        check("idle_rs5_pending", rs_pending, 0);
        check("idle_rs5_stall",   ds_stall,   0);
        clear_decode();

        // Load-use hazard on r8
        issue(5'd8, 1'b1);
        tick();
        rt = 5'd8; rt_use = 1'b1;
        #1;
        check("lduse_stall",      ds_stall,      1);
        check("lduse_rt_ld_pend", rt_ld_pending, 1);
        check("lduse_rt_pend",    rt_pending,    1);
        ld_done_valid = 1'b1; ld_done_dest = 5'd8;
        #1;
        check("lduse_same_cycle", ds_stall, 1);
        tick();
        check("lddone_stall",     ds_stall,      0);
        check("lddone_rt_pend",   rt_pending,    1);
        check("lddone_rt_ld",     rt_ld_pending, 0);
        wb_valid = 1'b1; wb_dest = 5'd8;
        tick();
        check("wb8_rt_pend", rt_pending, 0);
        clear_decode();

        // Overflow stall on r3
        issue(5'd3, 1'b0);
        tick();
        issue(5'd3, 1'b0);
        tick();
        dest_q = 5'd3; dest_we_q = 1'b1;
        #1;
        check("r3_two_no_stall", ds_stall, 0);
        issue(5'd3, 1'b0);
        tick();
        check("r3_full_stall", ds_stall, 1);
        rs = 5'd3; rs_use = 1'b1;
        #1;
        check("r3_alu_no_ld", rs_ld_pending, 0);
        wb_valid = 1'b1; wb_dest = 5'd3;
        tick();
        check("r3_wb_unstall", ds_stall, 0);
        check("r3_still_pend", rs_pending, 1);
        wb_valid = 1'b1; wb_dest = 5'd3;
        tick();
        wb_valid = 1'b1; wb_dest = 5'd3;
        tick();
        check("r3_drained", rs_pending, 0);
        check("r3_no_err",  sb_err,     0);
        clear_decode();

        // Simultaneous issue and write-back on r4
        issue(5'd4, 1'b0);
        tick();
        issue(5'd4, 1'b0);
        wb_valid = 1'b1; wb_dest = 5'd4;
        tick();
        rs = 5'd4;
        #1;
        check("r4_net_pend", rs_pending, 1);
        check("r4_net_err",  sb_err,     0);
        wb_valid = 1'b1; wb_dest = 5'd4;
        tick();
        check("r4_count_was_1", rs_pending, 0);
        check("r4_err_clean",   sb_err,     0);
        clear_decode();

        // r0 never tracked
        issue(5'd0, 1'b1);
        tick();
        rs = 5'd0; rs_use = 1'b1; dest_q = 5'd0; dest_we_q = 1'b1;
        #1;
        check("r0_pend",    rs_pending,    0);
        check("r0_ld_pend", rs_ld_pending, 0);
        check("r0_stall",   ds_stall,      0);
        check("r0_err",     sb_err,        0);
        clear_decode();

        // Underflow on r9 sets the sticky error
        wb_valid = 1'b1; wb_dest = 5'd9;
        #1;
        check("underflow_not_yet", sb_err, 0);
        tick();
        rs = 5'd9;
        #1;
        check("underflow_err",  sb_err,     1);
        check("underflow_sat0", rs_pending, 0);

        // Flush clears loads in flight and beats a same-cycle issue
        issue(5'd6, 1'b1);
        tick();
        issue(5'd6, 1'b1);
        tick();
        rs = 5'd6; rs_use = 1'b1; rt = 5'd7; rt_use = 1'b1;
        #1;
        check("r6_two_loads_stall", ds_stall, 1);
        flush = 1'b1;
        issue(5'd7, 1'b1);
        tick();
        check("flush_rs_pend",    rs_pending,    0);
        check("flush_rs_ld_pend", rs_ld_pending, 0);
        check("flush_rt_pend",    rt_pending,    0);
        check("flush_stall",      ds_stall,      0);
        check("flush_err_sticky", sb_err,        1);
        clear_decode();

        // Asynchronous reset mid-operation
        issue(5'd10, 1'b1);
        tick();
        rs = 5'd10; rs_use = 1'b1;
        #1;
        check("r10_stall", ds_stall, 1);
        #1;
        resetn = 1'b0;
        #1;
        check("async_rst_stall",  ds_stall,   0);
        check("async_rst_pend",   rs_pending, 0);
        check("async_rst_err",    sb_err,     0);
        resetn = 1'b1;
        tick();
        check("post_rst_pend", rs_pending, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
